aes_key_schedule: RTL
=====================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the last round-key index emitted (AES-128 only).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port start, input, 1: a one-cycle request to begin expanding key_in.
REQ-005 Port key_in, input, 128: the cipher key, sampled only in the cycle start is accepted.
REQ-006 Port busy, output, 1: high from start acceptance until the final handshake.
REQ-007 Port rk_valid, output, 1: rk_data/rk_index hold a valid round key.
REQ-008 Port rk_ready, input, 1: the downstream add-round-key stage accepts the key.
REQ-009 Port rk_data, output, 128: the round key; word i SHALL occupy bits [32i+31:32i], byte 0 of each word at its LSBs, matching the state-column layout used by the round datapath.
REQ-010 Port rk_index, output, 4: the round number of rk_data, 0..NUM_ROUNDS.
REQ-011 Port done, output, 1: a one-cycle pulse after round key NUM_ROUNDS is accepted.

Function
REQ-012 FSM states: IDLE, EMIT; IDLE->EMIT on start; EMIT->IDLE on handshake with rk_index==NUM_ROUNDS.
REQ-013 A start in IDLE at edge N SHALL yield rk_valid=1, rk_index=0, rk_data=key_in (round key 0) after edge N.
REQ-014 A handshake is rk_valid&&rk_ready at a rising edge.
REQ-015 On a handshake with rk_index<NUM_ROUNDS, the next round key and rk_index+1 SHALL be registered at that edge; rk_valid stays 1; with rk_ready held high, throughput is one key per cycle.
REQ-016 While rk_valid=1 and rk_ready=0, rk_data and rk_index SHALL hold stable.
REQ-017 Next key: t = SubWord(RotWord(w3)) ^ rcon; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-018 RotWord moves byte 0 to byte 3 and bytes 1..3 down one position; SubWord applies the AES S-box per byte.
REQ-019 rcon SHALL be XORed into byte 0 only; the sequence is 01,02,04,08,10,20,40,80,1B,36; the doubling SHALL be GF(2^8) xtime with reduction polynomial 0x1B.
REQ-020 On the final handshake: rk_valid->0, busy->0, done=1 for exactly the next cycle, and the state returns to IDLE.
REQ-021 start while busy=1 SHALL be ignored, and key_in SHALL NOT be resampled.
REQ-022 start in the same cycle that done is high (i.e., in IDLE) SHALL be accepted normally.
REQ-023 rk_ready while rk_valid=0 SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, rk_valid=0, done=0, rk_index=0, rk_data=0, and rcon=01.
REQ-025 Reset mid-expansion SHALL abort with no done pulse; the first start after release SHALL restart from round key 0.

Structure
REQ-026 The S-box table (as a function), the rcon initial value, NUM_ROUNDS, and the FSM state enum SHALL reside in shared package aes_pkg.
REQ-027 Sub-module key_sub_word: combinational, 32-bit in/out, four S-box lookups.
REQ-028 There SHALL be no other sub-modules; rcon SHALL be a registered byte and not a lookup table.

Verification
REQ-029 Key 2b7e1516 28aed2a6 abf71588 09cf4f3c (FIPS-197 byte order, mapped per REQ-009), start, rk_ready=1 -> rk_index 0..10 on 11 consecutive cycles; index 1 = a0fafe17 88542cb1 23a33939 2a6c7605; index 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done pulses the next cycle.
REQ-030 Same key, rk_ready toggled pseudo-randomly -> same 11 keys in order, data stable while stalled, and no key skipped or duplicated.
REQ-031 Second start at index 4, with a different key_in -> ignored; the sequence completes with the original key.
REQ-032 rst_n asserted at index 6 while stalled -> outputs zero asynchronously and no done; a new start then emits index 0 equal to the new key_in.
REQ-033 All-zero key -> index 1 = 62636363 62636363 62636363 62636363; index 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
REQ-034 start asserted in the done cycle -> index 0 valid on the following cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, S-box lookup and FSM states.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // GF(2^8) doubling, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sub_word.sv
// key_sub_word: combinational AES SubWord, one S-box lookup per byte.
module key_sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);
    import aes_pkg::*;

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign sub[8*i +: 8] = sbox(word[8*i +: 8]);
    end

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one round key per
// handshake on a valid/ready stream, rcon kept as a running register.
module aes_key_schedule #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         done
);
    import aes_pkg::*;

    state_t       state, next_state;
    logic [7:0]   rcon;
    logic         handshake, last;
    logic [31:0]  rot, sub, t, w0, w1, w2, w3;

    assign last      = rk_index == 4'(NUM_ROUNDS);
    assign handshake = rk_valid && rk_ready;

    // RotWord: byte 0 of w3 moves to the top byte, the rest shift down
    assign rot = {rk_data[103:96], rk_data[127:104]};

    key_sub_word u_sub_word (
        .word (rot),
        .sub  (sub)
    );

    assign t  = sub ^ {24'h0, rcon};
    assign w0 = rk_data[31:0]   ^ t;
    assign w1 = rk_data[63:32]  ^ w0;
    assign w2 = rk_data[95:64]  ^ w1;
    assign w3 = rk_data[127:96] ^ w2;

    always_comb begin
        busy       = state == EMIT;
        rk_valid   = state == EMIT;
        next_state = (state == IDLE) ? (start ? EMIT : IDLE)
                                     : ((handshake && last) ? IDLE : EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            rcon     <= RCON_INIT;
        end else begin
            state <= next_state;
            done  <= handshake && last;
            if (state == IDLE && start) begin
                rk_data  <= key_in;
                rk_index <= '0;
                rcon     <= RCON_INIT;
            end else if (handshake && !last) begin
                rk_data  <= {w3, w2, w1, w0};
                rk_index <= rk_index + 4'd1;
                rcon     <= xtime(rcon);
            end
        end
    end

endmodule
